// File: rtl/ac_muldiv_unit.sv
// Multi-cycle Booth multiply / restoring divide stage that feeds the AC register.
// Define AC_MULDIV_SIGNED_DIV_EN to make divide signed (magnitude iteration plus sign fix-up).
module ac_muldiv_unit #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 5
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic         flush,
  output logic [W-1:0] ac_in,
  output logic         ac_en,
  output logic [W-1:0] aux_out,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic         dz
);

  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_reg;
  logic [W:0]    a_reg;
  logic [W-1:0]  q_reg;
  logic          q_1;
  logic [W-1:0]  m_reg;

`ifdef AC_MULDIV_SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction
`endif

  logic [W:0]   mul_sum;
  logic [W:0]   div_sh;
  logic [W:0]   div_trial;
  logic [W:0]   step_a;
  logic [W-1:0] step_q;
  logic         step_q1;
  logic [W-1:0] res_lo;
  logic [W-1:0] res_hi;
  logic         res_ovf;

  // One iteration of the selected algorithm, applied to the current register contents
  always_comb begin
    case ({q_reg[0], q_1})
      2'b01:   mul_sum = a_reg + {m_reg[W-1], m_reg};
      2'b10:   mul_sum = a_reg - {m_reg[W-1], m_reg};
      default: mul_sum = a_reg;
    endcase
    div_sh    = {a_reg[W-1:0], q_reg[W-1]};
    div_trial = div_sh - {1'b0, m_reg};
    step_q1   = q_reg[0];
    if (!op_reg) begin
      step_a = {mul_sum[W], mul_sum[W:1]};
      step_q = {mul_sum[0], q_reg[W-1:1]};
    end else begin
      step_a = div_trial[W] ? div_sh : div_trial;
      step_q = {q_reg[W-2:0], ~div_trial[W]};
    end
  end

  // Final results as seen after the last iteration
  always_comb begin
    res_lo  = step_q;
    res_hi  = step_a[W-1:0];
    res_ovf = 1'b0;
    if (!op_reg) begin
      res_ovf = (res_hi != {W{res_lo[W-1]}});
    end
`ifdef AC_MULDIV_SIGNED_DIV_EN
    else begin
      if (neg_q) res_lo = -step_q;
      if (neg_r) res_hi = -step_a[W-1:0];
      // Only a positive quotient of 2^(W-1) (i.e. MIN / -1) cannot be represented
      res_ovf = !neg_q && step_q[W-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      cnt     <= '0;
      op_reg  <= 1'b0;
      a_reg   <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      m_reg   <= '0;
`ifdef AC_MULDIV_SIGNED_DIV_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
      ac_in   <= '0;
      ac_en   <= 1'b0;
      aux_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
    end else begin
      ac_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_reg <= op;
            cnt    <= '0;
            busy   <= 1'b1;
            if (op && (opb == '0)) begin
              state   <= WB;
              ac_en   <= 1'b1;
              done    <= 1'b1;
              ac_in   <= '1;
              aux_out <= opa;
              dz      <= 1'b1;
              ovf     <= 1'b0;
            end else begin
              state <= CALC;
              a_reg <= '0;
              q_1   <= 1'b0;
              if (op) begin
`ifdef AC_MULDIV_SIGNED_DIV_EN
                q_reg <= mag(opa);
                m_reg <= mag(opb);
                neg_q <= opa[W-1] ^ opb[W-1];
                neg_r <= opa[W-1];
`else
                q_reg <= opa;
                m_reg <= opb;
`endif
              end else begin
                q_reg <= opb;
                m_reg <= opa;
              end
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            a_reg <= step_a;
            q_reg <= step_q;
            q_1   <= step_q1;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST_ITER) begin
              state   <= WB;
              ac_en   <= 1'b1;
              done    <= 1'b1;
              ac_in   <= res_lo;
              aux_out <= res_hi;
              ovf     <= res_ovf;
              dz      <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac_muldiv_unit.sv
// Directed self-checking bench for ac_muldiv_unit.
module tb_ac_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic        op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        flush;
  logic [15:0] ac_in;
  logic        ac_en;
  logic [15:0] aux_out;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        dz;

  int errors = 0;
  int checks = 0;

  ac_muldiv_unit #(.W(16), .CW(5)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .ac_in(ac_in), .ac_en(ac_en), .aux_out(aux_out),
    .busy(busy), .done(done), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start for one edge (E), then wait for ac_en; lat counts edges after E
  task automatic do_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    op = o; opa = a; opb = b; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!ac_en && lat < 40) begin
      step();
      lat++;
    end
  endtask

  int          lat;
  int          n_en;
  int          first;
  logic [15:0] cap_lo;
  logic [15:0] cap_hi;

  initial begin
    rst_b = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0; flush = 1'b0;
    #1;
    check("rst_ac_in", ac_in, 16'h0000);
    check("rst_aux", aux_out, 16'h0000);
    check("rst_flags", {ac_en, busy, done, ovf, dz}, 5'b00000);
    step();
    rst_b = 1'b1;
    step();

    // 3 * -5
    do_op(1'b0, 16'h0003, 16'hFFFB, lat);
    check("mul1_lat", lat, 16);
    check("mul1_lo", ac_in, 16'hFFF1);
    check("mul1_hi", aux_out, 16'hFFFF);
    check("mul1_flags", {ac_en, busy, done, ovf, dz}, 5'b11100);
    step();
    check("mul1_after", {ac_en, busy, done}, 3'b000);
    check("mul1_hold", ac_in, 16'hFFF1);

    // 300 * 300
    do_op(1'b0, 16'd300, 16'd300, lat);
    check("mul2_lat", lat, 16);
    check("mul2_res", {aux_out, ac_in}, 32'h0001_5F90);
    check("mul2_ovf", ovf, 1'b1);
    step();

    // -32768 * -32768
    do_op(1'b0, 16'h8000, 16'h8000, lat);
    check("mul3_res", {aux_out, ac_in}, 32'h4000_0000);
    check("mul3_ovf", ovf, 1'b1);
    step();

    // 100 / 7
    do_op(1'b1, 16'd100, 16'd7, lat);
    check("div1_lat", lat, 16);
    check("div1_res", {aux_out, ac_in}, 32'h0002_000E);
    check("div1_flags", {ovf, dz, done}, 3'b001);
    step();

    // 0xFFFF / 1
    do_op(1'b1, 16'hFFFF, 16'h0001, lat);
    check("div2_res", {aux_out, ac_in}, 32'h0000_FFFF);
    step();

    // divide by zero
    do_op(1'b1, 16'h1234, 16'h0000, lat);
    check("dz_lat", lat, 0);
    check("dz_res", {aux_out, ac_in}, 32'h1234_FFFF);
    check("dz_flags", {ac_en, busy, done, ovf, dz}, 5'b11101);
    step();
    check("dz_after", {ac_en, busy, dz}, 3'b001);

    // 100 * -3 with a second start mid-CALC and another during WB
    op = 1'b0; opa = 16'd100; opb = 16'hFFFD; start = 1'b1;
    step();
    start = 1'b0;
    n_en = 0; first = 0; cap_lo = '0; cap_hi = '0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 1) check("calc_busy", {busy, ac_en, done}, 3'b100);
      if (ac_en) begin
        n_en++;
        if (first == 0) first = i;
        cap_lo = ac_in;
        cap_hi = aux_out;
      end
      if (i == 4) begin start = 1'b1; op = 1'b1; opa = 16'd5; opb = 16'd5; end
      if (i == 5) start = 1'b0;
      if (i == 16) start = 1'b1;
      if (i == 17) begin start = 1'b0; check("wb_start_ign", busy, 1'b0); end
    end
    check("ign_count", n_en, 1);
    check("ign_lat", first, 16);
    check("ign_res", {cap_hi, cap_lo}, 32'hFFFF_FED4);
    check("ign_dz_clr", dz, 1'b0);

    // flush at E+8
    op = 1'b0; opa = 16'd7; opb = 16'd6; start = 1'b1;
    step();
    start = 1'b0;
    n_en = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (ac_en || done) n_en++;
      if (i == 7) flush = 1'b1;
      if (i == 8) begin flush = 1'b0; check("flush_busy", busy, 1'b0); end
    end
    check("flush_no_en", n_en, 0);
    check("flush_hold", {aux_out, ac_in}, 32'hFFFF_FED4);

    // async reset mid-CALC
    op = 1'b0; opa = 16'd300; opb = 16'd300; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    check("pre_rst_busy", busy, 1'b1);
    rst_b = 1'b0;
    #1;
    check("mid_rst_res", {aux_out, ac_in}, 32'h0000_0000);
    check("mid_rst_flags", {ac_en, busy, done, ovf, dz}, 5'b00000);
    step();
    rst_b = 1'b1;
    n_en = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ac_en || busy) n_en++;
    end
    check("post_rst_idle", n_en, 0);

    do_op(1'b0, 16'd7, 16'd6, lat);
    check("mul4_lat", lat, 16);
    check("mul4_res", {aux_out, ac_in}, 32'h0000_002A);
    check("mul4_ovf", ovf, 1'b0);
    step();

`ifdef AC_MULDIV_SIGNED_DIV_EN
    do_op(1'b1, 16'hFFF9, 16'h0002, lat);
    check("sdiv1_lat", lat, 16);
    check("sdiv1_res", {aux_out, ac_in}, 32'hFFFF_FFFD);
    check("sdiv1_ovf", ovf, 1'b0);
    step();
    do_op(1'b1, 16'h8000, 16'hFFFF, lat);
    check("sdiv2_res", {aux_out, ac_in}, 32'h0000_8000);
    check("sdiv2_ovf", ovf, 1'b1);
    step();
`else
    do_op(1'b1, 16'hFFF9, 16'h0002, lat);
    check("udiv3_res", {aux_out, ac_in}, 32'h0001_7FFC);
    check("udiv3_ovf", ovf, 1'b0);
    step();
    do_op(1'b1, 16'h8000, 16'hFFFF, lat);
    check("udiv4_res", {aux_out, ac_in}, 32'h8000_0000);
    check("udiv4_ovf", ovf, 1'b0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ac_muldiv_unit.md
Name: ac_muldiv_unit

Overview:
- Multi-cycle multiply/divide stage that sits directly upstream of the accumulator register AC.
- Drives AC's `en`/`in` pair: a one-cycle `ac_en` pulse with the 16-bit result on `ac_in`.
- AC's bypass makes the result visible on AC's output in the same cycle.
- Secondary result (product high half / remainder) is held on `aux_out`, for a neighbouring register (e.g. the multiplier-quotient register).

Parameters:
- `W`, 16: operand/result width; iteration count equals `W`.
- `CW`, 5: iteration counter width, must satisfy `2^CW > W`.

Ports:
- `clk`  input  1  system clock, rising edge
- `rst_b`  input  1  asynchronous active-low reset
- `start`  input  1  request; sampled only in IDLE
- `op`  input  1  0 = signed multiply (Booth radix-2), 1 = unsigned divide (restoring)
- `opa`  input  `W`  multiplicand / dividend
- `opb`  input  `W`  multiplier / divisor
- `flush`  input  1  synchronous abort, returns the unit to IDLE
- `ac_in`  output  `W`  result to AC: product low half or quotient
- `ac_en`  output  1  one-cycle write strobe to AC
- `aux_out`  output  `W`  product high half or remainder; held until next WB
- `busy`  output  1  high in CALC and WB
- `done`  output  1  one-cycle pulse, coincident with `ac_en`
- `ovf`  output  1  multiply: product does not fit signed `W` bits; divide: 0
- `dz`  output  1  divide by zero occurred; held until next WB

Behaviour:
- Clock and reset (already decided): one clock `clk`; reset `rst_b` is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counter 0, internal accumulators 0.
- States: IDLE, CALC, WB.
- IDLE:
  - `start=1` at edge E latches `opa`, `opb`, `op`, clears the counter, and enters CALC.
  - Exception: `op=1` with `opb==0` goes straight to WB.
- CALC:
  - One iteration per edge, E+1 .. E+16.
  - The edge that completes iteration `W-1` enters WB.
- WB:
  - Lasts exactly one cycle.
  - `ac_en=1`, `done=1`; `ac_in`, `aux_out`, `ovf`, `dz` updated and valid.
  - Next edge goes to IDLE.
- Latency:
  - `ac_en` is high in the cycle after edge E+16 (17 cycles from the start-sampling edge).
  - Divide-by-zero: high in the cycle after E.
- Multiply:
  - Booth radix-2 on a `{A[W], Q[W], q-1}` register, arithmetic right shift each iteration.
  - `A` is `W+1` bits internally so that -32768 * -32768 is correct.
  - Product = `{A[W-1:0], Q}`; `ac_in` = low half, `aux_out` = high half.
  - `ovf` = high half != replicate(low half MSB).
- Divide:
  - Restoring, unsigned; `W+1`-bit partial remainder.
  - Quotient to `ac_in`, remainder to `aux_out`.
- Divide by zero: `ac_in = 16'hFFFF`, `aux_out = opa`, `dz = 1`, `ovf = 0`.
- `busy` is 1 from the cycle after E through the WB cycle inclusive; `start` is ignored while `busy=1`.
- Boundary conditions:
  - `ac_in`/`aux_out` hold their last WB values in IDLE and CALC.
  - `ac_en` is never high outside WB.
  - `flush=1`: next edge forces IDLE, no `ac_en`/`done`, result outputs unchanged; `flush` has priority over `start` and over WB.
  - `start` in the same cycle as WB is ignored; a new operation needs `start` in IDLE.
  - `rst_b` low mid-CALC: immediate IDLE with all outputs 0; no partial write reaches AC.
  - Operands changing after E: no effect.

Optional Feature:
- Macro: `AC_MULDIV_SIGNED_DIV_EN`.
- Defined:
  - Divide is signed. Operands converted to magnitudes at E; the iteration is unchanged.
  - In WB the quotient is negated if sign(`opa`) != sign(`opb`), and the remainder takes the sign of `opa`.
  - -32768 / -1 gives `ac_in = 16'h8000` with `ovf = 1`.
  - Divide by zero is as above.
  - Latency is unchanged.
- Undefined: divide is unsigned only and `ovf` is always 0 for divide.

Test Plan:
- Multiply 3 * -5 (`opa = 0x0003`, `opb = 0xFFFB`) -> `ac_en` 17 cycles after E; `ac_in = 0xFFF1`, `aux_out = 0xFFFF`, `ovf = 0`.
- Multiply 300 * 300 -> `ac_in = 0x5F90`, `aux_out = 0x0001`, `ovf = 1`; also -32768 * -32768 -> `ac_in = 0x0000`, `aux_out = 0x4000`, `ovf = 1`.
- Divide 100 / 7 -> `ac_in = 0x000E`, `aux_out = 0x0002`, `dz = 0`; 0xFFFF / 1 -> `ac_in = 0xFFFF`, `aux_out = 0`.
- Divide 0x1234 / 0 -> `ac_en` in the cycle after E; `ac_in = 0xFFFF`, `aux_out = 0x1234`, `dz = 1`.
- `start` pulsed again at E+5 with different operands -> ignored, single `ac_en`, original result; `flush` at E+8 -> no `ac_en`, `busy = 0` next cycle.
- `rst_b` low at E+10 -> all outputs 0 immediately, IDLE; a fresh multiply 7 * 6 afterwards -> `ac_in = 0x002A`. With `AC_MULDIV_SIGNED_DIV_EN` defined: -7 / 2 -> `ac_in = 0xFFFD`, `aux_out = 0xFFFF`.
